// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline.
// Combines Tuse/Tnew data hazards, HI/LO multiply-divide occupancy and
// interrupt/exception flushes into the PC, IF/ID and ID/EX enable/clear
// controls. It also owns the MD busy sequencer, so decode and the MD unit
// see the same occupancy.
// Optional build macro HAZARD_STATS_EN adds the stall_cnt and flush_cnt
// event counters.
module pipe_hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_rs_addr,
    input  logic [4:0]       d_rt_addr,
    input  logic [1:0]       d_rs_tuse,
    input  logic [1:0]       d_rt_tuse,
    input  logic             d_is_md,
    input  logic [4:0]       e_wr_addr,
    input  logic [1:0]       e_tnew,
    input  logic [4:0]       m_wr_addr,
    input  logic [1:0]       m_tnew,
    input  logic             e_md_start,
    input  logic             e_md_is_div,
    input  logic             mem_wait,
    input  logic             int_req,
    output logic             pc_en,
    output logic             IF_ID_en,
    output logic             ID_EX_en,
    output logic             ID_EX_clr,
    output logic             int_clr,
    output logic             stall,
    output logic             md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [15:0]      flush_cnt
`endif
);

    // Counter load values: the counter runs N-1 down to 0, so busy lasts N cycles
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    md_state_t        state_r;
    md_state_t        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             md_busy_r;
    logic             md_busy_nxt_s;

    logic             hz_rs_e_s;
    logic             hz_rs_m_s;
    logic             hz_rt_e_s;
    logic             hz_rt_m_s;
    logic             hz_data_s;
    logic             stall_md_s;
    logic             stall_s;
    logic             md_accept_s;

    // Data hazards: a producer ahead of D whose result is not ready by the time D needs it
    always_comb begin
        hz_rs_e_s = (e_wr_addr != 5'd0) && (e_wr_addr == d_rs_addr) && (e_tnew > d_rs_tuse);
        hz_rs_m_s = (m_wr_addr != 5'd0) && (m_wr_addr == d_rs_addr) && (m_tnew > d_rs_tuse);
        hz_rt_e_s = (e_wr_addr != 5'd0) && (e_wr_addr == d_rt_addr) && (e_tnew > d_rt_tuse);
        hz_rt_m_s = (m_wr_addr != 5'd0) && (m_wr_addr == d_rt_addr) && (m_tnew > d_rt_tuse);
        hz_data_s = hz_rs_e_s | hz_rs_m_s | hz_rt_e_s | hz_rt_m_s;
        // An op being started in E occupies HI/LO just like a running one
        stall_md_s  = d_is_md & (md_busy_r | e_md_start);
        // A flush or a frozen front end makes a D stall meaningless
        stall_s     = (hz_data_s | stall_md_s) & ~int_req & ~mem_wait;
        // The MD op only launches when E actually advances and is not flushed
        md_accept_s = e_md_start & ~int_req & ~mem_wait;
    end

    // Pipeline control priority: flush, then bus freeze, then D stall
    always_comb begin
        pc_en     = 1'b1;
        IF_ID_en  = 1'b1;
        ID_EX_en  = 1'b1;
        ID_EX_clr = 1'b0;
        int_clr   = 1'b0;
        if (int_req) begin
            int_clr   = 1'b1;
        end else if (mem_wait) begin
            pc_en     = 1'b0;
            IF_ID_en  = 1'b0;
            ID_EX_en  = 1'b0;
        end else if (stall_s) begin
            pc_en     = 1'b0;
            IF_ID_en  = 1'b0;
            ID_EX_clr = 1'b1;
        end else begin
            pc_en     = 1'b1;
        end
    end

    assign stall   = stall_s;
    assign md_busy = md_busy_r;

    // MD sequencer next state; a started op always runs to completion
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        md_busy_nxt_s = md_busy_r;
        case (state_r)
            ST_IDLE: begin
                if (md_accept_s) begin
                    state_nxt_s   = ST_BUSY;
                    cnt_nxt_s     = e_md_is_div ? DIV_LOAD : MULT_LOAD;
                    md_busy_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s     = CNT_ZERO;
                    md_busy_nxt_s = 1'b0;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s   = ST_IDLE;
                    md_busy_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s     = cnt_r - CNT_ONE;
                    md_busy_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                cnt_nxt_s     = CNT_ZERO;
                md_busy_nxt_s = 1'b0;
            end
        endcase
    end

    // MD sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            md_busy_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            md_busy_r <= md_busy_nxt_s;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // Event counters for D stalls and pipeline flushes, wrapping at full width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (stall_s) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (int_clr) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl: hand-computed expectations per scenario.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs_addr;
    logic [4:0] d_rt_addr;
    logic [1:0] d_rs_tuse;
    logic [1:0] d_rt_tuse;
    logic       d_is_md;
    logic [4:0] e_wr_addr;
    logic [1:0] e_tnew;
    logic [4:0] m_wr_addr;
    logic [1:0] m_tnew;
    logic       e_md_start;
    logic       e_md_is_div;
    logic       mem_wait;
    logic       int_req;
    logic       pc_en;
    logic       IF_ID_en;
    logic       ID_EX_en;
    logic       ID_EX_clr;
    logic       int_clr;
    logic       stall;
    logic       md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .d_rs_addr   (d_rs_addr),
        .d_rt_addr   (d_rt_addr),
        .d_rs_tuse   (d_rs_tuse),
        .d_rt_tuse   (d_rt_tuse),
        .d_is_md     (d_is_md),
        .e_wr_addr   (e_wr_addr),
        .e_tnew      (e_tnew),
        .m_wr_addr   (m_wr_addr),
        .m_tnew      (m_tnew),
        .e_md_start  (e_md_start),
        .e_md_is_div (e_md_is_div),
        .mem_wait    (mem_wait),
        .int_req     (int_req),
        .pc_en       (pc_en),
        .IF_ID_en    (IF_ID_en),
        .ID_EX_en    (ID_EX_en),
        .ID_EX_clr   (ID_EX_clr),
        .int_clr     (int_clr),
        .stall       (stall),
        .md_busy     (md_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        d_rs_addr = 5'd0; d_rt_addr = 5'd0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
        d_is_md = 1'b0; e_wr_addr = 5'd0; e_tnew = 2'd0; m_wr_addr = 5'd0;
        m_tnew = 2'd0; e_md_start = 1'b0; e_md_is_div = 1'b0; mem_wait = 1'b0;
        int_req = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        d_rs_tuse = 2'd0; d_rt_tuse = 2'd0;
        reset = 1'b1;
        step(); step();
        #2;
        vec_cnt++; if (md_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_md_busy got=%b exp=0", md_busy); end
        reset = 1'b0;
        step();
        #2;
        vec_cnt++;
        if ({pc_en, IF_ID_en, ID_EX_en, ID_EX_clr, int_clr, stall, md_busy} !== 7'b1110000) begin
            err_cnt++;
            $display("FAIL reset_idle_outputs got=%b exp=1110000",
                     {pc_en, IF_ID_en, ID_EX_en, ID_EX_clr, int_clr, stall, md_busy});
        end
    endtask

    task automatic test_load_use();
        clear_inputs(); step();
        d_rs_addr = 5'd5; d_rs_tuse = 2'd1; e_wr_addr = 5'd5; e_tnew = 2'd2;
        #2;
        vec_cnt++;
        if ({stall, pc_en, IF_ID_en, ID_EX_en, ID_EX_clr} !== 5'b10011) begin
            err_cnt++;
            $display("FAIL load_use_stall got=%b exp=10011", {stall, pc_en, IF_ID_en, ID_EX_en, ID_EX_clr});
        end
        step();
        e_wr_addr = 5'd0; e_tnew = 2'd0; m_wr_addr = 5'd5; m_tnew = 2'd1;
        #2;
        vec_cnt++;
        if ({stall, pc_en, ID_EX_clr} !== 3'b010) begin
            err_cnt++;
            $display("FAIL load_use_release got=%b exp=010", {stall, pc_en, ID_EX_clr});
        end
        // rt path through M: tnew 1 > tuse 0
        clear_inputs(); d_rt_addr = 5'd7; d_rt_tuse = 2'd0; m_wr_addr = 5'd7; m_tnew = 2'd1;
        #2;
        vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL rt_m_hazard got=%b exp=1", stall); end
        // unsigned top value: tnew 3 > tuse 2
        clear_inputs(); d_rt_addr = 5'd9; d_rt_tuse = 2'd2; e_wr_addr = 5'd9; e_tnew = 2'd3;
        #2;
        vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL rt_e_tnew3 got=%b exp=1", stall); end
        // tuse 3 never stalls
        d_rt_tuse = 2'd3;
        #2;
        vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL tuse3_no_stall got=%b exp=0", stall); end
        // address mismatch
        clear_inputs(); d_rs_addr = 5'd4; d_rs_tuse = 2'd0; e_wr_addr = 5'd6; e_tnew = 2'd2;
        #2;
        vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL addr_mismatch got=%b exp=0", stall); end
    endtask

    task automatic test_reg0();
        clear_inputs(); d_rs_addr = 5'd0; d_rs_tuse = 2'd0; e_wr_addr = 5'd0; e_tnew = 2'd2;
        m_wr_addr = 5'd0; m_tnew = 2'd2;
        #2;
        vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL reg0_no_stall got=%b exp=0", stall); end
    endtask

    task automatic test_mult_mfhi();
        clear_inputs(); step();
        d_is_md = 1'b1; e_md_start = 1'b1; e_md_is_div = 1'b0;
        #2;
        vec_cnt++;
        if ({stall, md_busy, ID_EX_clr} !== 3'b101) begin
            err_cnt++; $display("FAIL mult_start_cycle got=%b exp=101", {stall, md_busy, ID_EX_clr});
        end
        step();
        e_md_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            vec_cnt++;
            if ({stall, md_busy} !== 2'b11) begin
                err_cnt++; $display("FAIL mult_busy_cyc%0d got=%b exp=11", i, {stall, md_busy});
            end
            step();
        end
        #2;
        vec_cnt++;
        if ({stall, md_busy, pc_en} !== 3'b001) begin
            err_cnt++; $display("FAIL mult_mfhi_issue got=%b exp=001", {stall, md_busy, pc_en});
        end
    endtask

    task automatic test_div_mem_wait();
        clear_inputs(); step();
        e_md_start = 1'b1; e_md_is_div = 1'b1; mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            vec_cnt++;
            if ({md_busy, pc_en, ID_EX_en, stall} !== 4'b0000) begin
                err_cnt++; $display("FAIL div_wait_cyc%0d got=%b exp=0000", i, {md_busy, pc_en, ID_EX_en, stall});
            end
            step();
        end
        mem_wait = 1'b0;
        #2;
        vec_cnt++; if (md_busy !== 1'b0) begin err_cnt++; $display("FAIL div_accept_cycle got=%b exp=0", md_busy); end
        step();
        e_md_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_wait = (i == 3 || i == 4) ? 1'b1 : 1'b0;
            #2;
            vec_cnt++;
            if (md_busy !== 1'b1) begin err_cnt++; $display("FAIL div_busy_cyc%0d got=%b exp=1", i, md_busy); end
            step();
        end
        mem_wait = 1'b0;
        #2;
        vec_cnt++; if (md_busy !== 1'b0) begin err_cnt++; $display("FAIL div_done got=%b exp=0", md_busy); end
    endtask

    task automatic test_int_priority();
        clear_inputs(); step();
        int_req = 1'b1; e_md_start = 1'b1; d_is_md = 1'b1;
        d_rs_addr = 5'd5; d_rs_tuse = 2'd1; e_wr_addr = 5'd5; e_tnew = 2'd2;
        #2;
        vec_cnt++;
        if ({int_clr, stall, ID_EX_clr, pc_en, IF_ID_en, ID_EX_en} !== 6'b100111) begin
            err_cnt++;
            $display("FAIL int_priority got=%b exp=100111", {int_clr, stall, ID_EX_clr, pc_en, IF_ID_en, ID_EX_en});
        end
        mem_wait = 1'b1;
        #2;
        vec_cnt++;
        if ({int_clr, pc_en, ID_EX_en} !== 3'b111) begin
            err_cnt++; $display("FAIL int_over_mem_wait got=%b exp=111", {int_clr, pc_en, ID_EX_en});
        end
        mem_wait = 1'b0;
        step();
        clear_inputs();
        #2;
        vec_cnt++; if (md_busy !== 1'b0) begin err_cnt++; $display("FAIL int_no_md_start got=%b exp=0", md_busy); end
        // bus freeze overrides a data hazard
        d_rs_addr = 5'd5; d_rs_tuse = 2'd1; e_wr_addr = 5'd5; e_tnew = 2'd2; mem_wait = 1'b1;
        #2;
        vec_cnt++;
        if ({stall, pc_en, IF_ID_en, ID_EX_en, ID_EX_clr, int_clr} !== 6'b000000) begin
            err_cnt++;
            $display("FAIL mem_wait_priority got=%b exp=000000", {stall, pc_en, IF_ID_en, ID_EX_en, ID_EX_clr, int_clr});
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs(); step();
        e_md_start = 1'b1; e_md_is_div = 1'b0;
        step();
        // a start while busy is ignored: busy must still end after 5 cycles
        for (int i = 0; i < 5; i++) begin
            e_md_start = (i == 1) ? 1'b1 : 1'b0;
            #2;
            vec_cnt++;
            if (md_busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_busy_cyc%0d got=%b exp=1", i, md_busy); end
            step();
        end
        e_md_start = 1'b1;
        #2;
        vec_cnt++; if (md_busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_idle_gap got=%b exp=0", md_busy); end
        step();
        e_md_start = 1'b0;
        #2;
        vec_cnt++; if (md_busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_restart got=%b exp=1", md_busy); end
        for (int i = 0; i < 5; i++) step();
        #2;
        vec_cnt++; if (md_busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_second_done got=%b exp=0", md_busy); end
    endtask

    task automatic test_reset_busy();
        clear_inputs(); step();
        e_md_start = 1'b1; e_md_is_div = 1'b1;
        step();
        e_md_start = 1'b0;
        step(); step(); step();
        #2;
        vec_cnt++; if (md_busy !== 1'b1) begin err_cnt++; $display("FAIL rst_busy_pre got=%b exp=1", md_busy); end
        reset = 1'b1;
        #1;
        vec_cnt++; if (md_busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy_async got=%b exp=0", md_busy); end
`ifdef HAZARD_STATS_EN
        vec_cnt++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0) begin
            err_cnt++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
`endif
        step();
        reset = 1'b0;
        step();
        #2;
        vec_cnt++; if (md_busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy_stays_idle got=%b exp=0", md_busy); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_reg0();
        test_mult_mfhi();
        test_div_mem_wait();
        test_int_priority();
        test_back_to_back();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
